// File: rtl/alu_result_accumulator.sv
// Sums NUM_TERMS consecutive ALU results into a saturating accumulator and
// hands the finished sum downstream over valid/ready. Optional: ACC_CARRY_COUNT_EN.
module alu_result_accumulator #(
  parameter int NBITS     = 7,
  parameter int ACC_W     = 16,
  parameter int NUM_TERMS = 4,
  localparam int CNT_W    = $clog2(NUM_TERMS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NBITS+1:0]   in_y,
  input  logic               in_co,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_ovf,
`ifdef ACC_CARRY_COUNT_EN
  output logic [CNT_W-1:0]   carry_cnt,
`endif
  output logic [CNT_W-1:0]   term_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic             ovf_reg, ovf_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [ACC_W-1:0] out_sum_reg, out_sum_next;
  logic             out_ovf_reg, out_ovf_next;
  logic [CNT_W-1:0] carry_reg, carry_next;

  logic             accept;
  logic             handshake;
  logic             last_term;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] acc_add;
  logic             ovf_add;
  logic [ACC_W-1:0] y_ext;
  logic [CNT_W-1:0] co_ext;

  assign in_ready  = (state_reg != S_HOLD) && !clear;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid_reg && out_ready;
  assign last_term = (cnt_reg == CNT_W'(NUM_TERMS - 1));

  assign y_ext    = {{(ACC_W - NBITS - 2){1'b0}}, in_y};
  assign co_ext   = {{(CNT_W - 1){1'b0}}, in_co};
  assign sum_wide = {1'b0, acc_reg} + {1'b0, y_ext};
  // Once the sticky flag is set the accumulator is pinned at all ones.
  assign ovf_add  = ovf_reg || sum_wide[ACC_W];
  assign acc_add  = ovf_add ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    ovf_next       = ovf_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_sum_next   = out_sum_reg;
    out_ovf_next   = out_ovf_reg;
    carry_next     = carry_reg;
    if (clear) begin
      state_next     = S_IDLE;
      acc_next       = '0;
      ovf_next       = 1'b0;
      cnt_next       = '0;
      out_valid_next = 1'b0;
      carry_next     = '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            acc_next   = y_ext;
            ovf_next   = 1'b0;
            cnt_next   = CNT_W'(1);
            carry_next = co_ext;
            if (NUM_TERMS == 1) begin
              out_sum_next   = y_ext;
              out_ovf_next   = 1'b0;
              out_valid_next = 1'b1;
              state_next     = S_HOLD;
            end else begin
              state_next = S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          if (accept) begin
            acc_next   = acc_add;
            ovf_next   = ovf_add;
            cnt_next   = cnt_reg + CNT_W'(1);
            carry_next = carry_reg + co_ext;
            if (last_term) begin
              out_sum_next   = acc_add;
              out_ovf_next   = ovf_add;
              out_valid_next = 1'b1;
              state_next     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (handshake) begin
            out_valid_next = 1'b0;
            acc_next       = '0;
            ovf_next       = 1'b0;
            cnt_next       = '0;
            carry_next     = '0;
            state_next     = S_IDLE;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      acc_reg       <= '0;
      ovf_reg       <= 1'b0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_ovf_reg   <= 1'b0;
      carry_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      ovf_reg       <= ovf_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_sum_reg   <= out_sum_next;
      out_ovf_reg   <= out_ovf_next;
      carry_reg     <= carry_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_ovf   = out_ovf_reg;
  assign term_cnt  = cnt_reg;

`ifdef ACC_CARRY_COUNT_EN
  assign carry_cnt = carry_reg;
`else
  // Without the carry counter its register is dead logic and trims away.
  logic [CNT_W-1:0] unused_carry;
  assign unused_carry = carry_reg;
`endif

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Directed vector table, hand-written corner sequences and a randomized run
// checked against a queue-based model of the accumulator.
module tb_alu_result_accumulator;
  localparam int NBITS     = 7;
  localparam int ACC_W     = 10;
  localparam int NUM_TERMS = 4;
  localparam int CNT_W     = $clog2(NUM_TERMS + 1);
  localparam int MAXV      = (1 << ACC_W) - 1;

  logic clk = 1'b0;
  logic rst, clear, in_valid, in_ready, in_co, out_valid, out_ready, out_ovf;
  logic [NBITS+1:0] in_y;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] term_cnt;
`ifdef ACC_CARRY_COUNT_EN
  logic [CNT_W-1:0] carry_cnt;
`endif

  always #5 clk = ~clk;

  alu_result_accumulator #(.NBITS(NBITS), .ACC_W(ACC_W), .NUM_TERMS(NUM_TERMS)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_co(in_co), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf),
`ifdef ACC_CARRY_COUNT_EN
    .carry_cnt(carry_cnt),
`endif
    .term_cnt(term_cnt)
  );

  int tests = 0;
  int failed = 0;

  // Reference model: the terms of the sum in progress plus the last result.
  int   m_y[$];
  bit   m_co[$];
  bit   m_hold = 0;
  int   m_sum = 0;
  bit   m_ovf = 0;
  bit   m_rdy;
  logic rdy_seen;

  function automatic int m_carry();
    int c = 0;
    foreach (m_co[i]) c += int'(m_co[i]);
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, sample in_ready, advance the model at the edge.
  task automatic drive(input bit v, input int y, input bit co, input bit ordy,
                       input bit clr, input bit r);
    int total;
    in_valid = v; in_y = y[NBITS+1:0]; in_co = co; out_ready = ordy;
    clear = clr; rst = r;
    #1;
    rdy_seen = in_ready;
    m_rdy = !m_hold && !clr;
    @(posedge clk);
    if (r) begin
      m_hold = 0; m_y.delete(); m_co.delete(); m_sum = 0; m_ovf = 0;
    end else if (clr) begin
      m_hold = 0; m_y.delete(); m_co.delete();
    end else if (m_hold) begin
      if (ordy) begin
        $display("[TB] sum taken: %0d ovf=%0d", m_sum, m_ovf);
        m_hold = 0; m_y.delete(); m_co.delete();
      end
    end else if (v) begin
      m_y.push_back(y);
      m_co.push_back(co);
      if (m_y.size() == NUM_TERMS) begin
        total = 0;
        foreach (m_y[i]) total += m_y[i];
        m_sum  = (total > MAXV) ? MAXV : total;
        m_ovf  = (total > MAXV);
        m_hold = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_rdy"}, int'(rdy_seen), int'(m_rdy));
    chk({tag, "_valid"}, int'(out_valid), int'(m_hold));
    chk({tag, "_cnt"}, int'(term_cnt), m_y.size());
    if (m_hold) begin
      chk({tag, "_sum"}, int'(out_sum), m_sum);
      chk({tag, "_ovf"}, int'(out_ovf), int'(m_ovf));
`ifdef ACC_CARRY_COUNT_EN
      chk({tag, "_carry"}, int'(carry_cnt), m_carry());
`endif
    end
  endtask

  typedef struct {
    bit v; int y; bit co; bit ordy; bit clr;
    bit e_rdy; bit e_valid; int e_sum; bit e_ovf; int e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit v, int y, bit ordy, bit clr, bit e_rdy,
                              bit e_valid, int e_sum, bit e_ovf, int e_cnt);
    vec_t t;
    t.v = v; t.y = y; t.co = 1'b0; t.ordy = ordy; t.clr = clr;
    t.e_rdy = e_rdy; t.e_valid = e_valid; t.e_sum = e_sum; t.e_ovf = e_ovf; t.e_cnt = e_cnt;
    return t;
  endfunction

  initial begin
    // Four terms back-to-back, then the handshake.
    vecs.push_back(mk(1, 10, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 20, 1, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 30, 1, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 40, 1, 0, 1, 1, 100, 0, 4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Saturation, then an ordinary sum must come out clean.
    vecs.push_back(mk(1, 511, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 511, 1, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 511, 1, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 5, 1, 0, 1, 1, 1023, 1, 4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 1, 0, 1, 1, 4, 0, 4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));
    // Clear mid-sum; the term offered alongside clear is dropped.
    vecs.push_back(mk(1, 7, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 8, 1, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 99, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 2, 1, 0, 1, 0, 0, 0, 2));
    vecs.push_back(mk(1, 3, 1, 0, 1, 0, 0, 0, 3));
    vecs.push_back(mk(1, 4, 1, 0, 1, 1, 10, 0, 4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0));

    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sum", int'(out_sum), 0);
    chk("rst_ovf", int'(out_ovf), 0);
    chk("rst_cnt", int'(term_cnt), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].y, vecs[i].co, vecs[i].ordy, vecs[i].clr, 0);
      chk($sformatf("tbl%0d_rdy", i), int'(rdy_seen), int'(vecs[i].e_rdy));
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(vecs[i].e_valid));
      chk($sformatf("tbl%0d_cnt", i), int'(term_cnt), vecs[i].e_cnt);
      if (vecs[i].e_valid) begin
        chk($sformatf("tbl%0d_sum", i), int'(out_sum), vecs[i].e_sum);
        chk($sformatf("tbl%0d_ovf", i), int'(out_ovf), int'(vecs[i].e_ovf));
      end
    end

    // Backpressure: result must hold and no term may slip in.
    for (int i = 0; i < 4; i++) drive(1, 50, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 77, 0, 0, 0, 0);
      chk("bp_rdy", int'(rdy_seen), 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_sum", int'(out_sum), 200);
      chk("bp_cnt", int'(term_cnt), 4);
    end
    drive(1, 77, 0, 1, 0, 0);
    chk("bp_hs_valid", int'(out_valid), 0);
    chk("bp_hs_cnt", int'(term_cnt), 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 0, 0, 0, 0);
      chk("bp_next_cnt", int'(term_cnt), i);
    end
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_sum", int'(out_sum), 10);
    drive(0, 0, 0, 1, 0, 0);

    // Reset while holding a result.
    drive(1, 10, 0, 0, 0, 0); drive(1, 20, 0, 0, 0, 0);
    drive(1, 30, 0, 0, 0, 0); drive(1, 40, 0, 0, 0, 0);
    chk("hold_sum", int'(out_sum), 100);
    drive(1, 5, 0, 1, 0, 1);
    chk("rsthold_valid", int'(out_valid), 0);
    chk("rsthold_sum", int'(out_sum), 0);
    chk("rsthold_ovf", int'(out_ovf), 0);
    chk("rsthold_cnt", int'(term_cnt), 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rsthold_rdy", int'(rdy_seen), 1);

`ifdef ACC_CARRY_COUNT_EN
    drive(1, 3, 1, 0, 0, 0); drive(1, 5, 0, 0, 0, 0);
    drive(1, 9, 1, 0, 0, 0); drive(1, 2, 1, 0, 0, 0);
    chk("carry_sum", int'(out_sum), 19);
    chk("carry_cnt", int'(carry_cnt), 3);
    drive(0, 0, 0, 1, 0, 0);
`endif

    for (int n = 0; n < 400; n++) begin
      bit v, co, ordy, clr;
      int y;
      v    = ($urandom_range(0, 9) < 7);
      co   = $urandom_range(0, 1) != 0;
      ordy = $urandom_range(0, 1) != 0;
      clr  = ($urandom_range(0, 39) == 0);
      y    = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 200) : $urandom_range(300, 511);
      drive(v, y, co, ordy, clr, 0);
      chk_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
